reg_file_sb: RTL and testbench

//  Parametrised 2-read/1-write register file with a dedicated write address port.

---
 rtl/reg_file_sb_if.sv | 39 +++
 rtl/reg_file_sb.sv | 100 ++++++++++
 tb/tb_reg_file_sb.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// ----------------------------------------------------------------------------
// reg_file_sb_if
// Bundles the read, write and scoreboard signals of reg_file_sb.
//   master : decode/execute side -- drives addresses, write and busy_set
//            strobes; receives read data and busy flags.
//   slave  : the register file itself.
// Signals
//   rs_addr/rt_addr  [AW]  read port A/B address
//   wr_en, wr_addr, wr_data  write port
//   busy_set, busy_addr      mark a register as pending
//   rs_val_o/rt_val_o [DW]  read data A/B (combinational)
//   rs_busy_o/rt_busy_o     pending flag for the register on port A/B
// ----------------------------------------------------------------------------
interface reg_file_sb_if #(
  parameter int AW = 3,
  parameter int DW = 8
);
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy_set;
  logic [AW-1:0] busy_addr;
  logic [DW-1:0] rs_val_o;
  logic [DW-1:0] rt_val_o;
  logic          rs_busy_o;
  logic          rt_busy_o;

  modport master (
    output rs_addr, rt_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
    input  rs_val_o, rt_val_o, rs_busy_o, rt_busy_o
  );

  modport slave (
    input  rs_addr, rt_addr, wr_en, wr_addr, wr_data, busy_set, busy_addr,
    output rs_val_o, rt_val_o, rs_busy_o, rt_busy_o
  );
endinterface

// File: rtl/reg_file_sb.sv
// ----------------------------------------------------------------------------
// reg_file_sb
// 2-read/1-write register file with a per-register busy scoreboard that
// tracks outstanding long-latency (load) results. Sits between decode and
// execute; the busy flags feed the hazard/stall logic.
// Parameters
//   AW        address width, depth = 2**AW
//   DW        data width
//   BYPASS    1: a same-cycle write is forwarded to matching read ports and
//             clears their busy flag
//   ZERO_REG  1: register 0 reads 0, ignores writes, is never busy
//   RESET_VAL value every register takes on reset
// Ports
//   clk    clock, all state updates on the rising edge
//   reset  asynchronous, active-high; clears the array and the scoreboard
//   bus    reg_file_sb_if slave modport (read/write/scoreboard signals)
// ----------------------------------------------------------------------------
module reg_file_sb #(
  parameter int              AW        = 3,
  parameter int              DW        = 8,
  parameter int              BYPASS    = 1,
  parameter int              ZERO_REG  = 0,
  parameter logic [DW-1:0]   RESET_VAL = '0
) (
  input logic         clk,
  input logic         reset,
  reg_file_sb_if.slave bus
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    rf [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nxt;

  logic             wr_ok;   // write reaches the array
  logic             set_ok;  // busy_set reaches the scoreboard
  logic [DW-1:0]    rs_val;
  logic [DW-1:0]    rt_val;
  logic             rs_busy;
  logic             rt_busy;

  assign wr_ok  = bus.wr_en    && !(ZERO_REG != 0 && bus.wr_addr   == '0);
  assign set_ok = bus.busy_set && !(ZERO_REG != 0 && bus.busy_addr == '0);

  // Scoreboard next state: the retiring write clears first, then a new issue
  // sets, so a set to the same address in the same cycle wins.
  // NOTE: combinational blocks use blocking '=' with every output defaulted
  // first, so the later assignment wins and no latch is inferred.
  always_comb begin
    busy_nxt = busy;
    if (bus.wr_en) busy_nxt[bus.wr_addr] = 1'b0;
    if (set_ok)    busy_nxt[bus.busy_addr] = 1'b1;
  end

  // NOTE: the array is a flop bank, not a RAM macro, so it takes the async
  // reset like any other state; sequential blocks use non-blocking '<='.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= RESET_VAL;
      busy <= '0;
    end else begin
      if (wr_ok) rf[bus.wr_addr] <= bus.wr_data;
      busy <= busy_nxt;
    end
  end

  // Read ports. The bypass is gated by reset so an in-flight write cannot
  // leak through while the file is being cleared. The zero register check
  // comes last so it overrides the bypass.
  always_comb begin
    rs_val  = rf[bus.rs_addr];
    rs_busy = busy[bus.rs_addr];
    if (BYPASS != 0 && !reset && bus.wr_en && bus.wr_addr == bus.rs_addr) begin
      rs_val  = bus.wr_data;
      rs_busy = 1'b0;
    end
    if (ZERO_REG != 0 && bus.rs_addr == '0) begin
      rs_val  = '0;
      rs_busy = 1'b0;
    end

    rt_val  = rf[bus.rt_addr];
    rt_busy = busy[bus.rt_addr];
    if (BYPASS != 0 && !reset && bus.wr_en && bus.wr_addr == bus.rt_addr) begin
      rt_val  = bus.wr_data;
      rt_busy = 1'b0;
    end
    if (ZERO_REG != 0 && bus.rt_addr == '0) begin
      rt_val  = '0;
      rt_busy = 1'b0;
    end
  end

  assign bus.rs_val_o  = rs_val;
  assign bus.rt_val_o  = rt_val;
  assign bus.rs_busy_o = rs_busy;
  assign bus.rt_busy_o = rt_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// ----------------------------------------------------------------------------
// tb_reg_file_sb
// Drives three reg_file_sb instances with identical stimulus:
//   cfg 0: BYPASS=1 ZERO_REG=0   cfg 1: BYPASS=0 ZERO_REG=0
//   cfg 2: BYPASS=1 ZERO_REG=1
// Expected outputs are pushed to a queue as each stimulus is applied and
// popped when the combinational outputs are sampled mid low-phase.
// ----------------------------------------------------------------------------
module tb_reg_file_sb;

  localparam int       NCFG      = 3;
  localparam logic [2:0] BYP_MASK  = 3'b101;
  localparam logic [2:0] ZERO_MASK = 3'b100;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // shared stimulus
  logic [2:0] rs, rt, wa, ba;
  logic       we, bs;
  logic [7:0] wd;

  reg_file_sb_if #(.AW(3), .DW(8)) if_a ();
  reg_file_sb_if #(.AW(3), .DW(8)) if_b ();
  reg_file_sb_if #(.AW(3), .DW(8)) if_z ();

  reg_file_sb #(.AW(3), .DW(8), .BYPASS(1), .ZERO_REG(0), .RESET_VAL(8'h00))
    dut_a (.clk(clk), .reset(reset), .bus(if_a));
  reg_file_sb #(.AW(3), .DW(8), .BYPASS(0), .ZERO_REG(0), .RESET_VAL(8'h00))
    dut_b (.clk(clk), .reset(reset), .bus(if_b));
  reg_file_sb #(.AW(3), .DW(8), .BYPASS(1), .ZERO_REG(1), .RESET_VAL(8'h00))
    dut_z (.clk(clk), .reset(reset), .bus(if_z));

  assign if_a.rs_addr = rs;  assign if_b.rs_addr = rs;  assign if_z.rs_addr = rs;
  assign if_a.rt_addr = rt;  assign if_b.rt_addr = rt;  assign if_z.rt_addr = rt;
  assign if_a.wr_en   = we;  assign if_b.wr_en   = we;  assign if_z.wr_en   = we;
  assign if_a.wr_addr = wa;  assign if_b.wr_addr = wa;  assign if_z.wr_addr = wa;
  assign if_a.wr_data = wd;  assign if_b.wr_data = wd;  assign if_z.wr_data = wd;
  assign if_a.busy_set  = bs; assign if_b.busy_set  = bs; assign if_z.busy_set  = bs;
  assign if_a.busy_addr = ba; assign if_b.busy_addr = ba; assign if_z.busy_addr = ba;

  logic [7:0] o_rsv [NCFG];
  logic [7:0] o_rtv [NCFG];
  logic       o_rsb [NCFG];
  logic       o_rtb [NCFG];
  assign o_rsv[0] = if_a.rs_val_o;  assign o_rsv[1] = if_b.rs_val_o;  assign o_rsv[2] = if_z.rs_val_o;
  assign o_rtv[0] = if_a.rt_val_o;  assign o_rtv[1] = if_b.rt_val_o;  assign o_rtv[2] = if_z.rt_val_o;
  assign o_rsb[0] = if_a.rs_busy_o; assign o_rsb[1] = if_b.rs_busy_o; assign o_rsb[2] = if_z.rs_busy_o;
  assign o_rtb[0] = if_a.rt_busy_o; assign o_rtb[1] = if_b.rt_busy_o; assign o_rtb[2] = if_z.rt_busy_o;

  // reference state per configuration
  logic [7:0] m_rf   [NCFG][8];
  logic       m_busy [NCFG][8];

  typedef struct {
    string      tag;
    int         k;
    logic [7:0] rsv;
    logic [7:0] rtv;
    logic       rsb;
    logic       rtb;
  } exp_t;
  exp_t sbq[$];

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_val(input int k, input logic [2:0] a);
    logic [7:0] v;
    if (reset) v = 8'h00;
    else begin
      v = m_rf[k][a];
      if (BYP_MASK[k] && we && wa == a) v = wd;
    end
    if (ZERO_MASK[k] && a == 3'd0) v = 8'h00;
    return v;
  endfunction

  function automatic logic exp_busy(input int k, input logic [2:0] a);
    logic b;
    if (reset) b = 1'b0;
    else begin
      b = m_busy[k][a];
      if (BYP_MASK[k] && we && wa == a) b = 1'b0;
    end
    if (ZERO_MASK[k] && a == 3'd0) b = 1'b0;
    return b;
  endfunction

  task automatic clear_model();
    for (int k = 0; k < NCFG; k++)
      for (int i = 0; i < 8; i++) begin
        m_rf[k][i]   = 8'h00;
        m_busy[k][i] = 1'b0;
      end
  endtask

  task automatic push_exp(input string tag);
    exp_t e;
    for (int k = 0; k < NCFG; k++) begin
      e.tag = tag;
      e.k   = k;
      e.rsv = exp_val(k, rs);
      e.rtv = exp_val(k, rt);
      e.rsb = exp_busy(k, rs);
      e.rtb = exp_busy(k, rt);
      sbq.push_back(e);
    end
  endtask

  task automatic drive(input string tag, input logic [2:0] rs_i, input logic [2:0] rt_i,
                       input logic we_i, input logic [2:0] wa_i, input logic [7:0] wd_i,
                       input logic bs_i, input logic [2:0] ba_i);
    rs = rs_i; rt = rt_i; we = we_i; wa = wa_i; wd = wd_i; bs = bs_i; ba = ba_i;
    push_exp(tag);
  endtask

  task automatic compare_outs();
    exp_t e;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check($sformatf("%s/c%0d/rs_val",  e.tag, e.k), 32'(o_rsv[e.k]), 32'(e.rsv));
      check($sformatf("%s/c%0d/rt_val",  e.tag, e.k), 32'(o_rtv[e.k]), 32'(e.rtv));
      check($sformatf("%s/c%0d/rs_busy", e.tag, e.k), 32'(o_rsb[e.k]), 32'(e.rsb));
      check($sformatf("%s/c%0d/rt_busy", e.tag, e.k), 32'(o_rtb[e.k]), 32'(e.rtb));
    end
  endtask

  // advance one clock; the model commits at the same edge as the DUTs
  task automatic tick();
    @(posedge clk);
    if (!reset) begin
      for (int k = 0; k < NCFG; k++) begin
        if (we && !(ZERO_MASK[k] && wa == 3'd0)) m_rf[k][wa] = wd;
        if (we) m_busy[k][wa] = 1'b0;
        if (bs && !(ZERO_MASK[k] && ba == 3'd0)) m_busy[k][ba] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    rs = '0; rt = '0; we = 1'b0; wa = '0; wd = '0; bs = 1'b0; ba = '0;
    clear_model();
    @(negedge clk);

    // reset held: every address reads 0, writes/busy_set discarded
    for (int a = 0; a < 8; a++) begin
      drive("t1_rst", 3'(a), 3'(7 - a), 1'b1, 3'(a), 8'hFF, 1'b1, 3'(a));
      compare_outs();
      tick();
    end
    reset = 1'b0;
    for (int a = 0; a < 8; a++) begin
      drive("t1_read", 3'(a), 3'(a ^ 1), 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
      compare_outs();
      check("t1_post_rst_val", 32'(o_rsv[0]), 32'h00);
      tick();
    end

    // write with same-cycle read: bypass vs. no bypass
    drive("t2_wr", 3'd5, 3'd0, 1'b1, 3'd5, 8'hA5, 1'b0, 3'd0);
    compare_outs();
    check("t2_bypass", 32'(o_rsv[0]), 32'hA5);
    check("t2_no_bypass_old", 32'(o_rsv[1]), 32'h00);
    tick();
    drive("t2_hold", 3'd5, 3'd5, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    compare_outs();
    check("t2_no_bypass_new", 32'(o_rsv[1]), 32'hA5);
    tick();

    // busy set, then cleared by the retiring write
    drive("t3_set", 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd3);
    compare_outs();
    check("t3_set_not_visible", 32'(o_rtb[0]), 32'h0);
    tick();
    drive("t3_busy", 3'd0, 3'd3, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    compare_outs();
    check("t3_busy", 32'(o_rtb[0]), 32'h1);
    tick();
    drive("t3_wr", 3'd0, 3'd3, 1'b1, 3'd3, 8'h3C, 1'b0, 3'd0);
    compare_outs();
    check("t3_byp_busy", 32'(o_rtb[0]), 32'h0);
    check("t3_byp_val", 32'(o_rtv[0]), 32'h3C);
    check("t3_nobyp_busy", 32'(o_rtb[1]), 32'h1);
    tick();
    drive("t3_clr", 3'd3, 3'd3, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    compare_outs();
    check("t3_cleared", 32'(o_rsb[1]), 32'h0);
    tick();

    // set and clear to the same register in one cycle: set wins
    drive("t4_same", 3'd0, 3'd0, 1'b1, 3'd2, 8'h11, 1'b1, 3'd2);
    compare_outs();
    tick();
    drive("t4_chk", 3'd2, 3'd2, 1'b0, 3'd0, 8'h00, 1'b1, 3'd2);
    compare_outs();
    check("t4_busy", 32'(o_rsb[0]), 32'h1);
    check("t4_val", 32'(o_rtv[1]), 32'h11);
    tick();
    drive("t4_resets", 3'd2, 3'd1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    compare_outs();
    check("t4_still_busy", 32'(o_rsb[0]), 32'h1);
    tick();

    // register 0: hardwired zero only in cfg 2
    drive("t5_w0", 3'd0, 3'd0, 1'b1, 3'd0, 8'hFF, 1'b1, 3'd0);
    compare_outs();
    check("t5_zero_byp", 32'(o_rsv[2]), 32'h00);
    check("t5_plain_byp", 32'(o_rsv[0]), 32'hFF);
    tick();
    drive("t5_r0", 3'd0, 3'd0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    compare_outs();
    check("t5_zero_val", 32'(o_rsv[2]), 32'h00);
    check("t5_zero_busy", 32'(o_rsb[2]), 32'h0);
    check("t5_plain_busy", 32'(o_rsb[0]), 32'h1);
    tick();

    // asynchronous reset between edges
    drive("t6_w", 3'd0, 3'd0, 1'b1, 3'd6, 8'h77, 1'b1, 3'd4);
    compare_outs();
    tick();
    drive("t6_pre", 3'd6, 3'd4, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    compare_outs();
    check("t6_pre_val", 32'(o_rsv[0]), 32'h77);
    check("t6_pre_busy", 32'(o_rtb[0]), 32'h1);
    #1;
    reset = 1'b1;
    clear_model();
    push_exp("t6_rst");
    compare_outs();
    check("t6_rst_val", 32'(o_rsv[1]), 32'h00);
    check("t6_rst_busy", 32'(o_rtb[1]), 32'h0);
    tick();
    reset = 1'b0;
    drive("t6_after", 3'd6, 3'd4, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0);
    compare_outs();
    tick();

    // random traffic, including rs==rt and overlapping write/set addresses
    for (int n = 0; n < 80; n++) begin
      logic [2:0] r_rs;
      r_rs = 3'($urandom_range(0, 7));
      drive("rnd", r_rs, ($urandom_range(0, 3) == 0) ? r_rs : 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
      compare_outs();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
